// File: rtl/i2c_apb_pkg.sv
// rtl/i2c_apb_pkg.sv - shared encodings for the I2C target to APB bridge
// Contents:
//   I2C_BYTE_BITS : bits per I2C data/address byte
//   i2c_state_t   : byte-level FSM state of the I2C target
//   apb_phase_t   : phase of the outstanding APB master transfer
package i2c_apb_pkg;

    localparam int I2C_BYTE_BITS = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_W_APB,
        ST_DATA_ACK,
        ST_R_APB,
        ST_RDATA,
        ST_MACK,
        ST_WAIT_STOP
    } i2c_state_t;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_phase_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with edge and START/STOP detect
// Ports:
//   clk, rst            : system clock, synchronous active-low reset
//   scl_i, sda_i        : asynchronous bus levels
//   scl_rise, scl_fall  : one-cycle pulses on synchronized SCL edges
//   start_det, stop_det : SDA fall / rise while SCL is high
//   sda_s               : synchronized SDA level
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic scl_m, scl_s, scl_h;
    logic sda_m, sda_h;

    // Idle bus is high, so loading 1s avoids false edges leaving reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            scl_h <= 1'b1;
            sda_m <= 1'b1;
            sda_s <= 1'b1;
            sda_h <= 1'b1;
        end else begin
            scl_m <= scl_i;
            scl_s <= scl_m;
            scl_h <= scl_s;
            sda_m <= sda_i;
            sda_s <= sda_m;
            sda_h <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    // SCL must be high on both samples so an SDA change next to an SCL edge is not a condition.
    assign start_det = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

endmodule

// File: rtl/i2c_apb_slave.sv
// rtl/i2c_apb_slave.sv - I2C target that turns one addressed byte into one APB transfer
// Optional build macro: I2C_APB_SLVERR_NACK_EN (pslverr NACKs writes, reads return 8'hFF)
// Ports:
//   clk, rst                   : system clock, synchronous active-low reset
//   scl_i, sda_i               : asynchronous I2C bus levels
//   scl_oe, sda_oe             : 1 pulls the line low (scl_oe = clock stretch)
//   psel, penable, pwrite      : APB master control
//   paddr, pwdata              : APB address (window offset) and write data
//   prdata, pready, pslverr    : APB completer response
//   busy                       : address matched, transaction not yet back in IDLE
//   xfer_done                  : one-cycle pulse when the APB access completes
module i2c_apb_slave
    import i2c_apb_pkg::*;
#(
    parameter logic [6:0] ADDR_BASE     = 7'h50,
    parameter int         ADDR_WIN_BITS = 2,
    parameter int         APB_AW        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              scl_oe,
    output logic              sda_oe,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [APB_AW-1:0] paddr,
    output logic [7:0]        pwdata,
    input  logic [7:0]        prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy,
    output logic              xfer_done
);

    localparam logic [3:0] BYTE_CNT = 4'(I2C_BYTE_BITS);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_t state;
    apb_phase_t apb_phase;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       rw;
    logic       rel_pend;    // release scl_oe on the next cycle (SDA already set up)
    logic       pend_start;  // bus condition seen while the APB access was running
    logic       pend_stop;
    logic       addr_hit, bus_abort, ev_start, ev_stop, apb_err;
    logic [7:0] rd_byte;

    // shreg holds {addr[6:0], rw} after the address byte.
    assign addr_hit  = (shreg[7:ADDR_WIN_BITS+1] == ADDR_BASE[6:ADDR_WIN_BITS]);
    assign bus_abort = (start_det | stop_det) && (state != ST_IDLE) &&
                       (state != ST_W_APB) && (state != ST_R_APB);
    // The most recent bus condition decides where a finished APB access goes.
    assign ev_start  = start_det | (pend_start & ~stop_det);
    assign ev_stop   = stop_det | (pend_stop & ~start_det);

`ifdef I2C_APB_SLVERR_NACK_EN
    assign apb_err = pslverr;
`else
    logic unused_pslverr;
    assign unused_pslverr = pslverr;
    assign apb_err        = 1'b0;
`endif
    assign rd_byte = apb_err ? 8'hFF : prdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            apb_phase  <= APB_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            rw         <= 1'b0;
            rel_pend   <= 1'b0;
            pend_start <= 1'b0;
            pend_stop  <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            busy       <= 1'b0;
            xfer_done  <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            if (rel_pend) begin
                scl_oe   <= 1'b0;
                rel_pend <= 1'b0;
            end
            if (bus_abort) begin
                sda_oe   <= 1'b0;
                scl_oe   <= 1'b0;
                rel_pend <= 1'b0;
                bit_cnt  <= '0;
                if (start_det) begin
                    state <= ST_ADDR;
                end else begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_det) begin
                            state   <= ST_ADDR;
                            bit_cnt <= '0;
                        end
                    end
                    ST_ADDR, ST_WDATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == BYTE_CNT) begin
                            bit_cnt <= '0;
                            if (state == ST_WDATA) begin
                                state     <= ST_W_APB;
                                scl_oe    <= 1'b1;
                                psel      <= 1'b1;
                                pwrite    <= 1'b1;
                                pwdata    <= shreg;
                                apb_phase <= APB_SETUP;
                            end else if (addr_hit) begin
                                state  <= ST_ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shreg[0];
                                paddr  <= APB_AW'(shreg[ADDR_WIN_BITS:1]);
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            if (rw) begin
                                state     <= ST_R_APB;
                                scl_oe    <= 1'b1;
                                psel      <= 1'b1;
                                pwrite    <= 1'b0;
                                apb_phase <= APB_SETUP;
                            end else begin
                                state <= ST_WDATA;
                            end
                        end
                    end
                    ST_W_APB, ST_R_APB: begin
                        if (start_det) begin
                            pend_start <= 1'b1;
                            pend_stop  <= 1'b0;
                        end else if (stop_det) begin
                            pend_stop  <= 1'b1;
                            pend_start <= 1'b0;
                        end
                        case (apb_phase)
                            APB_SETUP: begin
                                penable   <= 1'b1;
                                apb_phase <= APB_ACCESS;
                            end
                            APB_ACCESS: begin
                                if (pready) begin
                                    psel       <= 1'b0;
                                    penable    <= 1'b0;
                                    xfer_done  <= 1'b1;
                                    apb_phase  <= APB_IDLE;
                                    pend_start <= 1'b0;
                                    pend_stop  <= 1'b0;
                                    if (ev_start) begin
                                        state   <= ST_ADDR;
                                        bit_cnt <= '0;
                                        scl_oe  <= 1'b0;
                                    end else if (ev_stop) begin
                                        state  <= ST_IDLE;
                                        busy   <= 1'b0;
                                        scl_oe <= 1'b0;
                                    end else if (state == ST_W_APB) begin
                                        state    <= ST_DATA_ACK;
                                        sda_oe   <= ~apb_err;
                                        rel_pend <= 1'b1;
                                    end else begin
                                        state    <= ST_RDATA;
                                        shreg    <= rd_byte;
                                        sda_oe   <= ~rd_byte[7];
                                        bit_cnt  <= '0;
                                        rel_pend <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                    ST_DATA_ACK: begin
                        if (scl_fall) begin
                            state  <= ST_WAIT_STOP;
                            sda_oe <= 1'b0;
                        end
                    end
                    ST_RDATA: begin
                        // MSB is already on SDA; each fall presents the next bit.
                        if (scl_fall) begin
                            if (bit_cnt == BYTE_CNT - 4'd1) begin
                                state  <= ST_MACK;
                                sda_oe <= 1'b0;
                            end else begin
                                shreg   <= {shreg[6:0], 1'b1};
                                sda_oe  <= ~shreg[6];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_MACK: begin
                        // The master's ACK/NACK carries no meaning for a single-byte read.
                        if (scl_rise) begin
                            state <= ST_WAIT_STOP;
                        end
                    end
                    ST_WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_apb_slave.md
Name: i2c_apb_slave

Overview:
- I2C target (responder) end of the I2C-APB bridge; the master side initiates transactions that this block decodes.
- Decodes START, 7-bit address + R/W, and one data byte from oversampled SCL/SDA.
- For each addressed transaction it issues exactly one APB master transfer: a write of the received byte, or a read whose byte is shifted back to the master.
- Holds SCL low (clock stretching) while the APB access is outstanding.

Parameters:
- ADDR_BASE, 7'h50, base I2C address of the responding window.
- ADDR_WIN_BITS, 2, window size is 2^ADDR_WIN_BITS addresses (default 0x50-0x53).
- APB_AW, 8, APB address width. paddr = zero-extended window offset (i2c_addr[ADDR_WIN_BITS-1:0]).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- scl_i  in  1  SCL bus level (asynchronous).
- sda_i  in  1  SDA bus level (asynchronous).
- scl_oe  out  1  1 = pull SCL low (stretch).
- sda_oe  out  1  1 = pull SDA low.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction, 1 = write.
- paddr  out  APB_AW  APB address.
- pwdata  out  8  APB write data.
- prdata  in  8  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.
- busy  out  1  high from address match until return to IDLE.
- xfer_done  out  1  one-cycle pulse when the APB access completes.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; FSM to IDLE; synchronizers loaded with 1. Reset wins over every other event, including mid-APB.
- Input sampling:
  - scl_i and sda_i pass through a 2-flop synchronizer plus one history flop.
  - SCL rise/fall = synced vs history.
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- Bit timing:
  - Bits are sampled on the detected SCL rising edge, MSB first.
  - sda_oe changes only on the cycle after a detected SCL falling edge, which gives hold time.
- FSM states: IDLE, ADDR, ADDR_ACK, WDATA, W_APB, DATA_ACK, R_APB, RDATA, MACK, WAIT_STOP.
- IDLE -> ADDR on START.
- ADDR: shift 8 bits (7 address bits + R/W).
  - On match (addr[6:ADDR_WIN_BITS] == ADDR_BASE[6:ADDR_WIN_BITS]) -> ADDR_ACK: drive sda_oe=1 for the 9th clock. busy=1 from this point.
  - On mismatch -> WAIT_STOP with sda released (NACK).
- ADDR_ACK, after the 9th SCL falling edge:
  - W=0 -> WDATA: release SDA.
  - R=1 -> R_APB: assert scl_oe and start an APB read.
- WDATA: shift 8 bits. On the 8th SCL falling edge, assert scl_oe and go to W_APB.
- APB access (W_APB and R_APB):
  - SETUP cycle: psel=1, penable=0.
  - ACCESS cycle: psel=1, penable=1, held until pready=1.
  - Next cycle: psel=penable=0, xfer_done pulses.
  - paddr, pwrite and pwdata are stable across the whole access.
- W_APB complete -> DATA_ACK: drive ACK (sda_oe=1), then release scl_oe one cycle later. After the 9th falling edge go to WAIT_STOP.
- R_APB complete:
  - Latch prdata and drive its MSB onto SDA.
  - Release scl_oe one cycle after SDA is set up.
  - Go to RDATA and shift 8 bits out on SCL falling edges.
- RDATA -> MACK: release SDA and sample the master's ACK/NACK on the 9th rise (ignored), then go to WAIT_STOP.
- WAIT_STOP: release SDA (further bytes are NACKed) and wait. STOP -> IDLE; START -> ADDR (repeated start).
- START or STOP in any state outside an APB access: abort and release SDA. If abort happens before W_APB, no APB write is issued.
- START or STOP during W_APB or R_APB: the APB access always completes (never truncated), then the FSM goes to ADDR (on START) or IDLE (on STOP).
- scl_oe is never asserted outside W_APB and R_APB, plus the one release cycle.

Optional Feature:
- Macro I2C_APB_SLVERR_NACK_EN.
- Defined:
  - pslverr=1 on a write makes DATA_ACK drive NACK (SDA released).
  - pslverr=1 on a read returns 8'hFF instead of prdata.
- Undefined: pslverr is ignored; a write is always ACKed and a read always returns prdata.

Decomposition:
- Package i2c_apb_pkg holds:
  - the FSM state encoding;
  - the APB phase encoding (IDLE/SETUP/ACCESS);
  - the constant I2C_BYTE_BITS=8.
- One natural sub-module, i2c_bus_sync: 2-flop synchronizer plus edge/START/STOP detection. It outputs scl_rise, scl_fall, start_det, stop_det and sda_s.

Test Plan:
- Write 0x50, data 0xA5, pready tied 1 -> address ACK and data ACK; exactly one APB write with paddr=0x00 and pwdata=0xA5; one xfer_done pulse.
- Read 0x51, prdata=0x5A -> APB read with paddr=0x01 and pwrite=0; master receives 0x5A; master NACK -> IDLE after STOP.
- Address 0x60 write -> NACK on the 9th bit; psel never asserted; busy stays 0.
- Write 0x52 with data 0xA6, pready delayed 6 cycles -> scl_oe=1 for the entire access; ACK follows; pwdata=0xA6 stable throughout.
- STOP after 4 data bits of a write to 0x53 -> no psel; FSM returns to IDLE; then a repeated-START read to 0x50 succeeds.
- With I2C_APB_SLVERR_NACK_EN, pslverr=1 -> write data byte NACKed and read returns 0xFF. Without the macro -> ACK, and prdata is returned.
